// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer for the 4-bit-opcode
// datapath (ALU, LW, SW, BR). It shares one memory port and one ALU across the
// whole instruction, and it detects illegal opcodes and memory-wait timeouts.
// Optional feature: define MC_CTRL_PERF_EN to build the 16-bit retired-
// instruction counter. When it is undefined, o_instr_count is tied to zero.
module multicycle_control #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic [3:0]  i_opcode,
    input  logic [1:0]  i_funct,
    input  logic        i_zero,
    input  logic        i_mem_ready,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic        o_ir_write,
    output logic        o_pc_write,
    output logic        o_pc_src,
    output logic        o_reg_write,
    output logic        o_mem_to_reg,
    output logic [3:0]  o_alu_op,
    output logic        o_busy,
    output logic        o_illegal_op,
    output logic        o_mem_error,
    output logic [2:0]  o_state,
    output logic [15:0] o_instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [3:0] OP_ALU = 4'd0;
    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_SW  = 4'd2;
    localparam logic [3:0] OP_BR  = 4'd3;

    // The wait counter holds the number of low cycles already seen. The current
    // low cycle is therefore the last one allowed when the count equals LIMIT-1.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

    state_t     r_state;
    logic [3:0] r_opcode;
    logic [1:0] r_funct;
    logic [7:0] r_wait_cnt;
    logic       r_stop_pending;
    logic       r_illegal_op;
    logic       r_mem_error;

    logic       w_busy;
    logic       w_stop_req;
    logic       w_timeout;
    state_t     w_retire_next;

    assign w_busy        = (r_state != S_IDLE) && (r_state != S_HALT);
    // A stop seen in the retiring cycle also counts as pending.
    assign w_stop_req    = r_stop_pending | i_stop;
    assign w_retire_next = w_stop_req ? S_IDLE : S_FETCH;
    assign w_timeout     = !i_mem_ready && (r_wait_cnt == WAIT_LAST);

    // Sequencer: state, latched instruction fields, wait counter, stop and sticky flags.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state        <= S_IDLE;
            r_opcode       <= OP_ALU;
            r_funct        <= 2'd0;
            r_wait_cnt     <= 8'd0;
            r_stop_pending <= 1'b0;
            r_illegal_op   <= 1'b0;
            r_mem_error    <= 1'b0;
        end else begin
            if (w_busy && i_stop)
                r_stop_pending <= 1'b1;
            r_wait_cnt <= 8'd0;
            case (r_state)
                S_IDLE: begin
                    if (i_start)
                        r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (i_mem_ready) begin
                        r_state <= S_DECODE;
                    end else if (w_timeout) begin
                        r_state     <= S_HALT;
                        r_mem_error <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    r_opcode <= i_opcode;
                    r_funct  <= i_funct;
                    if (i_opcode > OP_BR) begin
                        r_state      <= S_HALT;
                        r_illegal_op <= 1'b1;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (r_opcode)
                        OP_LW, OP_SW: r_state <= S_MEM;
                        OP_BR: begin
                            r_state <= w_retire_next;
                            if (w_stop_req)
                                r_stop_pending <= 1'b0;
                        end
                        default: r_state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (i_mem_ready) begin
                        if (r_opcode == OP_SW) begin
                            r_state <= w_retire_next;
                            if (w_stop_req)
                                r_stop_pending <= 1'b0;
                        end else begin
                            r_state <= S_WB;
                        end
                    end else if (w_timeout) begin
                        r_state     <= S_HALT;
                        r_mem_error <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_WB: begin
                    r_state <= w_retire_next;
                    if (w_stop_req)
                        r_stop_pending <= 1'b0;
                end
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes decoded from the registered state, the latched op and the live mem_ready/zero.
    always_comb begin
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_ir_write   = 1'b0;
        o_pc_write   = 1'b0;
        o_pc_src     = 1'b0;
        o_reg_write  = 1'b0;
        o_mem_to_reg = 1'b0;
        o_alu_op     = 4'd0;
        case (r_state)
            S_FETCH: begin
                o_mem_req  = 1'b1;
                o_ir_write = i_mem_ready;
                o_pc_write = i_mem_ready;
            end
            S_EXEC: begin
                case (r_opcode)
                    OP_LW, OP_SW: o_alu_op = 4'd1;
                    OP_BR: begin
                        o_alu_op   = 4'd2;
                        o_pc_write = i_zero;
                        o_pc_src   = i_zero;
                    end
                    default: o_alu_op = {2'b00, r_funct} + 4'd1;
                endcase
            end
            S_MEM: begin
                o_mem_req = 1'b1;
                o_mem_we  = (r_opcode == OP_SW);
            end
            S_WB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = (r_opcode == OP_LW);
            end
            default: ;
        endcase
    end

    assign o_busy       = w_busy;
    assign o_illegal_op = r_illegal_op;
    assign o_mem_error  = r_mem_error;
    assign o_state      = r_state;

`ifdef MC_CTRL_PERF_EN
    logic        w_retire;
    logic [15:0] r_instr_count;

    assign w_retire = ((r_state == S_EXEC) && (r_opcode == OP_BR))
                    || ((r_state == S_MEM) && i_mem_ready && (r_opcode == OP_SW))
                    || (r_state == S_WB);

    // Retired-instruction counter, wrapping at 16 bits.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n)
            r_instr_count <= 16'd0;
        else if (w_retire)
            r_instr_count <= r_instr_count + 16'd1;
    end

    assign o_instr_count = r_instr_count;
`else
    assign o_instr_count = 16'd0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control. It runs directed cycle vectors with
// hand-computed expected outputs, using WAIT_LIMIT = 4.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, mem_ready, zero;
    logic [3:0]  opcode;
    logic [1:0]  funct;
    logic        mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, mem_to_reg;
    logic [3:0]  alu_op;
    logic        busy, illegal_op, mem_error;
    logic [2:0]  state;
    logic [15:0] instr_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       nm;
        logic [32:0] v;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    logic [32:0] act;

    multicycle_control #(.WAIT_LIMIT(4)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_stop(stop),
        .i_opcode(opcode), .i_funct(funct), .i_zero(zero), .i_mem_ready(mem_ready),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_ir_write(ir_write),
        .o_pc_write(pc_write), .o_pc_src(pc_src), .o_reg_write(reg_write),
        .o_mem_to_reg(mem_to_reg), .o_alu_op(alu_op), .o_busy(busy),
        .o_illegal_op(illegal_op), .o_mem_error(mem_error), .o_state(state),
        .o_instr_count(instr_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] cnt_exp(input logic [15:0] c);
`ifdef MC_CTRL_PERF_EN
        return c;
`else
        return 16'd0 & c;
`endif
    endfunction

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e_mon = q.pop_front();
            act = {state, mem_req, mem_we, ir_write, pc_write, pc_src, reg_write,
                   mem_to_reg, alu_op, busy, illegal_op, mem_error, instr_count};
            n_checks++;
            if (act !== e_mon.v) begin
                n_fail++;
                $display("FAIL %s: got st=%0d strb=%b alu=%b flags=%b cnt=%0d, expected st=%0d strb=%b alu=%b flags=%b cnt=%0d",
                         e_mon.nm, act[32:30], act[29:23], act[22:19], act[18:16], act[15:0],
                         e_mon.v[32:30], e_mon.v[29:23], e_mon.v[22:19], e_mon.v[18:16], e_mon.v[15:0]);
            end
        end
    end

    // One clock cycle: in = {reset_n, start, stop, mem_ready, zero};
    // s = {mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, mem_to_reg};
    // fl = {busy, illegal_op, mem_error}.
    task automatic cyc(input string nm, input logic [4:0] in, input logic [3:0] op,
                       input logic [1:0] fn, input logic [2:0] st, input logic [6:0] s,
                       input logic [3:0] alu, input logic [2:0] fl, input logic [15:0] cnt);
        exp_t e;
        {rst_n, start, stop, mem_ready, zero} = in;
        opcode = op;
        funct  = fn;
        e.nm = nm;
        e.v  = {st, s, alu, fl, cnt_exp(cnt)};
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        {rst_n, start, stop, mem_ready, zero} = 5'b00000;
        opcode = 4'd0;
        funct  = 2'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc("reset_state",         5'b00000, 4'd0, 2'd0, 3'd0, 7'b0000000, 4'b0000, 3'b000, 16'd0);

        // Zero-wait program: ALU SUB, LW, BR taken, BR not taken with stop.
        cyc("t1_start",            5'b11010, 4'd0, 2'd0, 3'd0, 7'b0000000, 4'b0000, 3'b000, 16'd0);
        cyc("t1_fetch_alu",        5'b10010, 4'd0, 2'd0, 3'd1, 7'b1011000, 4'b0000, 3'b100, 16'd0);
        cyc("t1_decode_alu",       5'b10010, 4'd0, 2'd1, 3'd2, 7'b0000000, 4'b0000, 3'b100, 16'd0);
        cyc("t1_exec_alu_sub",     5'b10010, 4'd3, 2'd3, 3'd3, 7'b0000000, 4'b0010, 3'b100, 16'd0);
        cyc("t1_wb_alu",           5'b10010, 4'd3, 2'd3, 3'd5, 7'b0000010, 4'b0000, 3'b100, 16'd0);
        cyc("t1_fetch_lw",         5'b10010, 4'd0, 2'd0, 3'd1, 7'b1011000, 4'b0000, 3'b100, 16'd1);
        cyc("t1_decode_lw",        5'b10010, 4'd1, 2'd3, 3'd2, 7'b0000000, 4'b0000, 3'b100, 16'd1);
        cyc("t1_exec_lw",          5'b10010, 4'd3, 2'd0, 3'd3, 7'b0000000, 4'b0001, 3'b100, 16'd1);
        cyc("t1_mem_lw",           5'b10010, 4'd0, 2'd0, 3'd4, 7'b1000000, 4'b0000, 3'b100, 16'd1);
        cyc("t1_wb_lw",            5'b10010, 4'd0, 2'd0, 3'd5, 7'b0000011, 4'b0000, 3'b100, 16'd1);
        cyc("t1_fetch_br1",        5'b10010, 4'd0, 2'd0, 3'd1, 7'b1011000, 4'b0000, 3'b100, 16'd2);
        cyc("t1_decode_br1",       5'b10010, 4'd3, 2'd0, 3'd2, 7'b0000000, 4'b0000, 3'b100, 16'd2);
        cyc("t1_exec_br_taken",    5'b10011, 4'd0, 2'd0, 3'd3, 7'b0001100, 4'b0010, 3'b100, 16'd2);
        cyc("t1_fetch_br2",        5'b10010, 4'd0, 2'd0, 3'd1, 7'b1011000, 4'b0000, 3'b100, 16'd3);
        cyc("t1_decode_br2",       5'b10010, 4'd3, 2'd0, 3'd2, 7'b0000000, 4'b0000, 3'b100, 16'd3);
        cyc("t1_exec_br_not_taken",5'b10110, 4'd3, 2'd0, 3'd3, 7'b0000000, 4'b0010, 3'b100, 16'd3);
        cyc("t1_idle_after_stop",  5'b10000, 4'd0, 2'd0, 3'd0, 7'b0000000, 4'b0000, 3'b000, 16'd4);

        // SW with 3 wait cycles, fetch ready on wait cycle 4, stop in EXEC, then timeout.
        cyc("t2_start",            5'b11010, 4'd0, 2'd0, 3'd0, 7'b0000000, 4'b0000, 3'b000, 16'd4);
        cyc("t2_fetch_sw",         5'b10010, 4'd0, 2'd0, 3'd1, 7'b1011000, 4'b0000, 3'b100, 16'd4);
        cyc("t2_decode_sw",        5'b10010, 4'd2, 2'd0, 3'd2, 7'b0000000, 4'b0000, 3'b100, 16'd4);
        cyc("t2_exec_sw",          5'b10000, 4'd0, 2'd0, 3'd3, 7'b0000000, 4'b0001, 3'b100, 16'd4);
        cyc("t2_mem_wait1",        5'b10000, 4'd0, 2'd0, 3'd4, 7'b1100000, 4'b0000, 3'b100, 16'd4);
        cyc("t2_mem_wait2",        5'b10000, 4'd0, 2'd0, 3'd4, 7'b1100000, 4'b0000, 3'b100, 16'd4);
        cyc("t2_mem_wait3",        5'b10000, 4'd0, 2'd0, 3'd4, 7'b1100000, 4'b0000, 3'b100, 16'd4);
        cyc("t2_mem_ready",        5'b10010, 4'd0, 2'd0, 3'd4, 7'b1100000, 4'b0000, 3'b100, 16'd4);
        cyc("t2_fetch_wait1",      5'b10000, 4'd0, 2'd0, 3'd1, 7'b1000000, 4'b0000, 3'b100, 16'd5);
        cyc("t2_fetch_wait2",      5'b10000, 4'd0, 2'd0, 3'd1, 7'b1000000, 4'b0000, 3'b100, 16'd5);
        cyc("t2_fetch_wait3",      5'b10000, 4'd0, 2'd0, 3'd1, 7'b1000000, 4'b0000, 3'b100, 16'd5);
        cyc("t2_fetch_ready_w4",   5'b10010, 4'd0, 2'd0, 3'd1, 7'b1011000, 4'b0000, 3'b100, 16'd5);
        cyc("t2_decode_and",       5'b10000, 4'd0, 2'd2, 3'd2, 7'b0000000, 4'b0000, 3'b100, 16'd5);
        cyc("t2_exec_and_stop",    5'b10100, 4'd0, 2'd0, 3'd3, 7'b0000000, 4'b0011, 3'b100, 16'd5);
        cyc("t2_wb_and",           5'b10000, 4'd0, 2'd0, 3'd5, 7'b0000010, 4'b0000, 3'b100, 16'd5);
        cyc("t2_idle_stop_ignored",5'b10100, 4'd0, 2'd0, 3'd0, 7'b0000000, 4'b0000, 3'b000, 16'd6);
        cyc("t2_start_with_stop",  5'b11100, 4'd0, 2'd0, 3'd0, 7'b0000000, 4'b0000, 3'b000, 16'd6);
        cyc("t2_fetch_br",         5'b10010, 4'd0, 2'd0, 3'd1, 7'b1011000, 4'b0000, 3'b100, 16'd6);
        cyc("t2_decode_br",        5'b10010, 4'd3, 2'd0, 3'd2, 7'b0000000, 4'b0000, 3'b100, 16'd6);
        cyc("t2_exec_br",          5'b10000, 4'd0, 2'd0, 3'd3, 7'b0000000, 4'b0010, 3'b100, 16'd6);
        cyc("t2_fetch_to1",        5'b10000, 4'd0, 2'd0, 3'd1, 7'b1000000, 4'b0000, 3'b100, 16'd7);
        cyc("t2_fetch_to2",        5'b10000, 4'd0, 2'd0, 3'd1, 7'b1000000, 4'b0000, 3'b100, 16'd7);
        cyc("t2_fetch_to3",        5'b10000, 4'd0, 2'd0, 3'd1, 7'b1000000, 4'b0000, 3'b100, 16'd7);
        cyc("t2_fetch_to4",        5'b10000, 4'd0, 2'd0, 3'd1, 7'b1000000, 4'b0000, 3'b100, 16'd7);
        cyc("t2_halt_timeout",     5'b11010, 4'd0, 2'd0, 3'd7, 7'b0000000, 4'b0000, 3'b001, 16'd7);
        cyc("t2_halt_start",       5'b11010, 4'd0, 2'd0, 3'd7, 7'b0000000, 4'b0000, 3'b001, 16'd7);
        cyc("t2_reset_from_halt",  5'b00000, 4'd0, 2'd0, 3'd7, 7'b0000000, 4'b0000, 3'b001, 16'd7);
        cyc("t2_after_reset",      5'b10000, 4'd0, 2'd0, 3'd0, 7'b0000000, 4'b0000, 3'b000, 16'd0);

        // Illegal opcode halts, and start is then ignored until reset.
        cyc("t3_start",            5'b11010, 4'd0, 2'd0, 3'd0, 7'b0000000, 4'b0000, 3'b000, 16'd0);
        cyc("t3_fetch",            5'b10010, 4'd0, 2'd0, 3'd1, 7'b1011000, 4'b0000, 3'b100, 16'd0);
        cyc("t3_decode_illegal",   5'b10010, 4'd5, 2'd0, 3'd2, 7'b0000000, 4'b0000, 3'b100, 16'd0);
        cyc("t3_halt_illegal",     5'b11010, 4'd0, 2'd0, 3'd7, 7'b0000000, 4'b0000, 3'b010, 16'd0);
        cyc("t3_halt_start",       5'b11010, 4'd0, 2'd0, 3'd7, 7'b0000000, 4'b0000, 3'b010, 16'd0);
        cyc("t3_reset",            5'b00000, 4'd0, 2'd0, 3'd7, 7'b0000000, 4'b0000, 3'b010, 16'd0);
        cyc("t3_after_reset",      5'b10000, 4'd0, 2'd0, 3'd0, 7'b0000000, 4'b0000, 3'b000, 16'd0);

        // Reset mid-MEM abandons the request and clears a pending stop.
        cyc("t4_start",            5'b11010, 4'd0, 2'd0, 3'd0, 7'b0000000, 4'b0000, 3'b000, 16'd0);
        cyc("t4_fetch",            5'b10010, 4'd0, 2'd0, 3'd1, 7'b1011000, 4'b0000, 3'b100, 16'd0);
        cyc("t4_decode_lw",        5'b10010, 4'd1, 2'd0, 3'd2, 7'b0000000, 4'b0000, 3'b100, 16'd0);
        cyc("t4_exec_lw_stop",     5'b10100, 4'd0, 2'd0, 3'd3, 7'b0000000, 4'b0001, 3'b100, 16'd0);
        cyc("t4_mem_reset",        5'b00000, 4'd0, 2'd0, 3'd4, 7'b1000000, 4'b0000, 3'b100, 16'd0);
        cyc("t4_idle_after_reset", 5'b10000, 4'd0, 2'd0, 3'd0, 7'b0000000, 4'b0000, 3'b000, 16'd0);
        cyc("t4_restart",          5'b11010, 4'd0, 2'd0, 3'd0, 7'b0000000, 4'b0000, 3'b000, 16'd0);
        cyc("t4_fetch_br",         5'b10010, 4'd0, 2'd0, 3'd1, 7'b1011000, 4'b0000, 3'b100, 16'd0);
        cyc("t4_decode_br",        5'b10010, 4'd3, 2'd0, 3'd2, 7'b0000000, 4'b0000, 3'b100, 16'd0);
        cyc("t4_exec_br_taken",    5'b10011, 4'd0, 2'd0, 3'd3, 7'b0001100, 4'b0010, 3'b100, 16'd0);
        cyc("t4_fetch_no_stale_stop", 5'b00000, 4'd0, 2'd0, 3'd1, 7'b1000000, 4'b0000, 3'b100, 16'd1);
        cyc("t4_final_idle",       5'b10000, 4'd0, 2'd0, 3'd0, 7'b0000000, 4'b0000, 3'b000, 16'd0);

        @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the 4-bit-opcode datapath (ALU, LW, SW, BR).
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives PC/IR enables, the shared memory port handshake, register write-back and ALU operation selection.
- Detects illegal opcodes and memory-wait timeouts.
- Replaces per-opcode combinational decode so one memory port and one ALU serve the whole instruction.

## Interface
- `WAIT_LIMIT`, default 15: maximum consecutive wait cycles (mem_req high, mem_ready low) before timeout; legal range 1..255.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: begin execution from IDLE.
- `stop` in 1: finish the current instruction, then return to IDLE.
- `opcode` in 4: 0000 ALU, 0001 LW, 0010 SW, 0011 BR; sampled in DECODE.
- `funct` in 2: ALU sub-op, 00 ADD, 01 SUB, 10 AND, 11 OR; sampled in DECODE.
- `zero` in 1: ALU zero flag, sampled in EXEC for BR.
- `mem_ready` in 1: memory completion for the current request.
- `mem_req` out 1: memory request.
- `mem_we` out 1: memory write (SW only).
- `ir_write` out 1: load instruction register.
- `pc_write` out 1: update PC.
- `pc_src` out 1: 0 = PC+1, 1 = branch target.
- `reg_write` out 1: register file write.
- `mem_to_reg` out 1: write-back source is memory.
- `alu_op` out 4: 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0000 idle.
- `busy` out 1: state is not IDLE and not HALT.
- `illegal_op` out 1: sticky, set when an opcode greater than 0011 is decoded.
- `mem_error` out 1: sticky, set on wait timeout.
- `state` out 3: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=7.
- `instr_count` out 16: retired-instruction counter.

## Operation
- **IDLE:** `start` → FETCH. All strobes low.
- **FETCH:** mem_req=1, mem_we=0.
  - If mem_ready: ir_write=1, pc_write=1, pc_src=0 in that same cycle → DECODE.
- **DECODE:** latch opcode/funct into an internal register; later states use only the latched copy.
  - opcode greater than 0011 → HALT, with illegal_op set.
  - Otherwise → EXEC.
- **EXEC:**
  - ALU: alu_op from latched funct → WB.
  - LW/SW: alu_op=ADD (address) → MEM.
  - BR: alu_op=SUB. If zero: pc_write=1, pc_src=1. BR retires → FETCH, or IDLE if stop is pending.
- **MEM:** mem_req=1, mem_we=1 for SW, 0 for LW.
  - On mem_ready: LW → WB; SW retires → FETCH, or IDLE if stop is pending.
- **WB:** reg_write=1; mem_to_reg=1 for LW only. Instruction retires → FETCH, or IDLE if stop is pending.
- **HALT:** all strobes low; exits only via reset.
- **stop handling:** `stop` sampled high in any busy state sets stop_pending. It is cleared when entering IDLE. `stop` in IDLE is ignored.
- **Wait counter:**
  - Counts cycles in FETCH/MEM with mem_ready low.
  - Cleared on mem_ready and on every state change.
  - When the count reaches WAIT_LIMIT with mem_ready still low: → HALT, mem_error set.
- **instr_count:** increments by 1 on every retire; wraps 0xFFFF→0x0000.
- `mem_ready` outside FETCH/MEM is ignored.

## Timing
- All outputs are functions of registered state, the latched op and the current `mem_ready`/`zero`. ir_write, pc_write and reg_write are single-cycle pulses.
- **Reset:** state=IDLE and every output 0, including alu_op=0000, the sticky flags, instr_count, the wait counter and stop_pending. Reset takes effect on the next edge even mid-transaction. A memory request in flight is abandoned; mem_req drops the cycle after.
- **Zero-wait latency, start to next FETCH:** ALU 4 cycles, LW 5, SW 4, BR 3. Each wait cycle adds 1.
- **Handshake:** mem_req stays high and stable (with mem_we) until the cycle mem_ready is sampled high. It deasserts the following cycle unless the next state also requests.
- **Timeout boundary:** exactly WAIT_LIMIT low cycles → HALT on the next edge. mem_ready arriving on cycle WAIT_LIMIT itself completes normally.
- **start+stop together in IDLE:** start wins, stop is ignored, and one full instruction loop begins.

## Configuration
- `MC_CTRL_PERF_EN` defined: the 16-bit instr_count register is built, with the behaviour described in Operation.
- Undefined: instr_count is tied to 0 and no counter flops are synthesized. All other behaviour is identical.

## Test plan
- **Zero-wait program:** reset, start, mem_ready always 1, fetching opcode 0000/funct 01 then 0001 → alu_op=0010 in EXEC, reg_write pulse 4 cycles after start, mem_to_reg=1 on LW WB 5 cycles later, instr_count=2.
- **SW with 3 wait cycles:** mem_req and mem_we held high for 4 cycles in MEM, no reg_write, back to FETCH on the cycle after mem_ready.
- **BR:** zero=1 → pc_write with pc_src=1 in EXEC. zero=0 → no pc_write in EXEC. Both take 3 cycles.
- **Illegal opcode:** opcode 0101 → state=7, illegal_op=1, busy=0. `start` then has no effect until reset_n=0.
- **Timeout:** WAIT_LIMIT=4, mem_ready held low in FETCH → HALT after 4 wait cycles with mem_error=1. A second run with mem_ready high on wait cycle 4 → DECODE, no error.
- **Reset and stop:** reset_n low for one cycle mid-MEM → all outputs 0 next cycle. stop pulsed during an ALU instruction's EXEC → IDLE after WB, instr_count incremented once.
